skew_feeder: RTL and testbench
==============================

# skew_feeder

Edge feeder for the int8 systolic array. It buffers one K-deep tile of N-lane int8 column vectors and replays it as a skewed stream: lane i is delayed by i cycles, and zeros fill the lane outside its window. Because the PEs accumulate every cycle, the zero fill keeps the MAC sums exact. The block sits directly upstream of the array's row (inA) or column (inB) edge, one instance per edge.

## Interface
- `N`, default 4: number of lanes (array rows or columns fed).
- `K`, default 4: vector length; number of beats per tile.
- `DW`, default 8: element width, signed two's complement.

- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: `in_data` beat offered.
- `in_ready`, out, 1: beat accepted when `in_valid && in_ready`.
- `in_data`, in, N*DW: one column vector; lane i occupies bits `[i*DW +: DW]`.
- `out_valid`, out, 1: skewed stream step valid.
- `out_data`, out, N*DW: skewed lanes to the array edge; same lane packing as `in_data`.
- `done`, out, 1: one-cycle pulse after the last stream step.

## Operation
- FSM states are LOAD, STREAM and DONE. Reset state is LOAD.
- **LOAD**
  - `in_ready` = 1.
  - Each handshake writes beat `b[cnt]` into buffer row `cnt`, then `cnt++`.
  - A cycle with no handshake holds `cnt`. Gaps are legal.
  - On the handshake with `cnt == K-1`: go to STREAM, set `t = 0`, set `cnt = 0`.
- **STREAM**
  - `in_ready` = 0. `in_valid` is ignored. The buffer is frozen.
  - `out_valid` = 1.
  - Lane i of `out_data` = `b[t-i][i]` if `i <= t < i+K`; otherwise 0.
  - `t` increments every cycle. No stall input exists; the array consumes every cycle.
  - After step `t = K+N-2`: go to DONE.
- **DONE**
  - `done` = 1, `in_ready` = 0, `out_valid` = 0.
  - Next cycle: go to LOAD.
- **Output path**
  - `out_data` and `out_valid` are combinational from registered state, `t` and buffer contents. No path runs from `in_*` to `out_*`.
  - Data passes through unmodified. No arithmetic is performed; sign is preserved (-128 passes as 8'h80).
- **Counter widths**
  - `cnt` is `$clog2(K)` bits, minimum 1.
  - `t` is `$clog2(K+N-1)` bits, minimum 1.
  - Neither counter wraps within a phase.

## Timing
- **Reset (asynchronous, immediate)**
  - state = LOAD, `cnt` = 0, `t` = 0, buffer = 0.
  - `in_ready` = 1, `out_valid` = 0, `out_data` = 0, `done` = 0.
- **Stream start:** the last load handshake at edge E makes `out_valid` high from E.
  - High for exactly K+N-1 consecutive cycles.
  - `done` goes high for 1 cycle right after.
  - `in_ready` returns high the cycle after `done`.
- **Throughput:** one tile per K + (K+N-1) + 1 cycles, plus any input gaps.
- **Reset mid-LOAD or mid-STREAM:** the partial tile is discarded, outputs go to zero immediately, and no `done` is produced.
- **`in_valid` during STREAM or DONE:** never accepted and must not corrupt the buffer.
- **K = 1:** the single accepted beat goes straight to STREAM with N steps.
- **N = 1:** no skew; K steps.

## Structure
- Shared package `systolic_pkg` holds:
  - the `feeder_state_t` enum (LOAD, STREAM, DONE);
  - `DATA_W = 8`, used as the `DW` default and shared with the MAC PE.
- Single module; no sub-module. The buffer is a K×N×DW register array; the lane select is a generate loop over i.

## Test plan
- **Skew pattern**
  - Stimulus: reset, then N=K=4, beats `b[k][i] = 16k+i+1`, `in_valid` held high.
  - Response: `in_ready` drops after 4 beats; 7 `out_valid` cycles.
  - t=0: lanes {1,0,0,0}. t=3: {49,34,19,4}. t=6: {0,0,0,52}.
  - `done` pulses at cycle 7; `in_ready` = 1 at cycle 8.
- **Input gaps**
  - Stimulus: `in_valid` toggling 1,0,1,0,… during LOAD.
  - Response: still exactly 4 beats captured in order; stream identical to the skew-pattern scenario.
- **Ignored input**
  - Stimulus: `in_valid` = 1 with garbage data throughout STREAM and DONE.
  - Response: no handshake; stream unchanged.
  - Next tile loads correctly starting at `cnt = 0`.
- **Signed extremes**
  - Stimulus: all elements 8'h80 (-128) and 8'h7F alternating by beat.
  - Response: exact bit pass-through on every lane at the expected steps; zero padding is 8'h00.
- **Reset mid-stream**
  - Stimulus: assert `reset` at t=2.
  - Response: `out_valid`/`out_data` go to 0 immediately; no `done`.
  - After release: `in_ready` = 1 and a fresh tile streams correctly.
- **Back-to-back tiles with array check**
  - Stimulus: two tiles, with one `skew_feeder` per edge driving a 4×4 array.
  - Response: PE(r,c) results equal the int8 dot products of the matching row/column (golden model) after K+N-1+(r+c) cycles.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and widths for the int8 systolic array: feeder FSM states and
// the element width used by both the edge feeders and the MAC PEs.
package systolic_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/skew_feeder.sv
// Edge feeder for the systolic array: captures one K-beat tile of N-lane
// vectors, then replays it with lane i delayed by i cycles and zero-padded.
module skew_feeder
  import systolic_pkg::*;
#(
  parameter int N  = 4,
  parameter int K  = 4,
  parameter int DW = DATA_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] in_data,
  output logic            out_valid,
  output logic [N*DW-1:0] out_data,
  output logic            done
);

  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam int TW = (K + N - 1 > 1) ? $clog2(K + N - 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);
  localparam logic [TW-1:0] T_LAST   = TW'(K + N - 2);

  feeder_state_t   state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   t_q, t_d;
  logic            wr_en_s;
  logic            streaming_s;
  logic [N*DW-1:0] tile_q [K];

  // FSM state and phase counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_d     = t_q;
    wr_en_s = 1'b0;
    case (state_q)
      LOAD: begin
        if (in_valid) begin
          wr_en_s = 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = STREAM;
            cnt_d   = '0;
            t_d     = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          wr_en_s = 1'b0;
        end
      end
      STREAM: begin
        if (t_q == T_LAST) begin
          state_d = DONE;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      DONE: begin
        state_d = LOAD;
        t_d     = '0;
      end
      default: begin
        state_d = LOAD;
        cnt_d   = '0;
        t_d     = '0;
      end
    endcase
  end

  // Tile buffer; only LOAD handshakes write it, so it is frozen while streaming
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < K; k++) begin
        tile_q[k] <= '0;
      end
    end else if (wr_en_s) begin
      tile_q[cnt_q] <= in_data;
    end
  end

  assign streaming_s = (state_q == STREAM);
  assign in_ready    = (state_q == LOAD);
  assign out_valid   = streaming_s;
  assign done        = (state_q == DONE);

  // Lane i shows row t-i of the tile inside its K-step window, zero elsewhere
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic          hit_s;
    logic [CW-1:0] row_s;
    assign hit_s = streaming_s && (int'(t_q) >= i) && (int'(t_q) < i + K);
    assign row_s = CW'(int'(t_q) - i);
    assign out_data[i*DW +: DW] = hit_s ? tile_q[row_s][i*DW +: DW] : {DW{1'b0}};
  end

endmodule

// File: tb/tb_skew_feeder.sv
// Scoreboard bench for skew_feeder: randomized and directed tiles, a queue of
// expected stream steps, and a behavioural 4x4 array fed by two feeders.
module tb_skew_feeder;

  localparam int N  = 4;
  localparam int K  = 4;
  localparam int DW = 8;
  localparam int S  = K + N - 1;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            in_valid = 1'b0;
  logic [N*DW-1:0] in_data = '0;
  logic [N*DW-1:0] in_data_b = '0;
  logic            in_ready, out_valid, done;
  logic            in_ready_b, out_valid_b, done_b;
  logic [N*DW-1:0] out_data, out_data_b;

  always #5 clk = ~clk;

  skew_feeder #(.N(N), .K(K), .DW(DW)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_data(out_data), .done(done)
  );

  skew_feeder #(.N(N), .K(K), .DW(DW)) u_dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data_b), .out_valid(out_valid_b), .out_data(out_data_b), .done(done_b)
  );

  typedef struct {
    logic [N*DW-1:0] data;
    bit              last;
  } exp_t;

  exp_t exp_q[$];
  bit   done_pend = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  logic signed [DW-1:0] tile_a [K][N];
  logic signed [DW-1:0] tile_b [K][N];
  logic signed [DW-1:0] a_pipe [N][N];
  logic signed [DW-1:0] b_pipe [N][N];
  int                   acc [N][N];
  int                   g1 [N][N];
  int                   gsum [N][N];
  bit                   arr_clr = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endtask

  function automatic logic [N*DW-1:0] pack_a(input int k);
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = tile_a[k][i];
    return v;
  endfunction

  function automatic logic [N*DW-1:0] pack_b(input int k);
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = tile_b[k][i];
    return v;
  endfunction

  // Expected stream: step t, lane i carries element i of beat t-i when that beat exists
  task automatic push_expected();
    exp_t e;
    for (int t = 0; t < S; t++) begin
      e.data = '0;
      for (int i = 0; i < N; i++) begin
        if (t - i >= 0 && t - i < K) e.data[i*DW +: DW] = tile_a[t-i][i];
      end
      e.last = (t == S - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic rand_tiles();
    for (int k = 0; k < K; k++)
      for (int i = 0; i < N; i++) begin
        tile_a[k][i] = DW'($urandom);
        tile_b[k][i] = DW'($urandom);
      end
  endtask

  // Called at #1 after a rising edge with the DUT in LOAD
  task automatic load_tile(input bit gaps);
    for (int k = 0; k < K; k++) begin
      if (gaps) begin
        in_valid  = 1'b0;
        in_data   = N*DW'($urandom);
        in_data_b = N*DW'($urandom);
        @(posedge clk); #1;
      end
      chk("in_ready_load", in_ready, 1);
      in_valid  = 1'b1;
      in_data   = pack_a(k);
      in_data_b = pack_b(k);
      if (k == K - 1) push_expected();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Covers the S stream cycles plus the DONE cycle, optionally offering junk
  task automatic stream_wait(input bit garbage);
    for (int c = 0; c < S + 1; c++) begin
      chk("in_ready_busy", in_ready, 0);
      in_valid  = garbage;
      in_data   = N*DW'($urandom);
      in_data_b = N*DW'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("in_ready_after_done", in_ready, 1);
  endtask

  // Monitor: every valid step pops one expected entry; done must follow the last one
  always @(negedge clk) begin
    if (done_pend) begin
      chk("done_pulse", done, 1);
      done_pend <= 1'b0;
    end else if (done) begin
      chk("done_spurious", done, 0);
    end
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("out_valid_extra", out_valid, 0);
      end else begin
        chk("out_data", out_data, exp_q[0].data);
        if (exp_q[0].last) done_pend <= 1'b1;
        void'(exp_q.pop_front());
      end
    end
  end

  function automatic logic signed [DW-1:0] a_left(input int r, input int c);
    if (c == 0) return out_valid ? $signed(out_data[r*DW +: DW]) : 8'sd0;
    return a_pipe[r][c-1];
  endfunction

  function automatic logic signed [DW-1:0] b_top(input int r, input int c);
    if (r == 0) return out_valid_b ? $signed(out_data_b[c*DW +: DW]) : 8'sd0;
    return b_pipe[r-1][c];
  endfunction

  // Output-stationary 4x4 MAC array: A moves right, B moves down
  always @(posedge clk) begin
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        if (arr_clr) begin
          a_pipe[r][c] <= '0;
          b_pipe[r][c] <= '0;
          acc[r][c]    <= 0;
        end else begin
          a_pipe[r][c] <= a_left(r, c);
          b_pipe[r][c] <= b_top(r, c);
          acc[r][c]    <= acc[r][c] + int'(a_left(r, c)) * int'(b_top(r, c));
        end
      end
  end

  task automatic add_golden(output int g [N][N]);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        g[r][c] = 0;
        for (int k = 0; k < K; k++) g[r][c] += int'(tile_a[k][r]) * int'(tile_b[k][c]);
      end
  endtask

  task automatic check_array(input string name, input int g [N][N]);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) chk(name, acc[r][c], g[r][c]);
  endtask

  initial begin
    int g2 [N][N];

    // Reset state
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_done", done, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Skew pattern b[k][i] = 16k+i+1, contiguous then with gaps
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < K; k++)
        for (int i = 0; i < N; i++) begin
          tile_a[k][i] = DW'(16 * k + i + 1);
          tile_b[k][i] = DW'($urandom);
        end
      load_tile(pass == 1);
      stream_wait(1'b0);
    end

    // Junk offered during STREAM/DONE, then a fresh tile
    for (int n = 0; n < 3; n++) begin
      rand_tiles();
      load_tile($urandom_range(0, 1) == 1);
      stream_wait(1'b1);
    end

    // Signed extremes alternating by beat
    for (int k = 0; k < K; k++)
      for (int i = 0; i < N; i++) tile_a[k][i] = (k % 2 == 0) ? 8'h80 : 8'h7F;
    load_tile(1'b0);
    stream_wait(1'b1);

    // Reset at t=2
    rand_tiles();
    load_tile(1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_done", done, 0);
    chk("midrst_in_ready", in_ready, 1);
    exp_q.delete();
    done_pend = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < S + 2; c++) begin
      chk("post_rst_in_ready", in_ready, 1);
      @(posedge clk); #1;
    end
    rand_tiles();
    load_tile(1'b0);
    stream_wait(1'b0);

    // Back-to-back tiles into the array model
    arr_clr = 1'b1;
    @(posedge clk); #1;
    arr_clr = 1'b0;
    rand_tiles();
    add_golden(g1);
    load_tile(1'b0);
    fork
      begin
        repeat (K + N) @(posedge clk);
        #1;
        rand_tiles();
        add_golden(g2);
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++) gsum[r][c] = g1[r][c] + g2[r][c];
        load_tile(1'b0);
      end
      begin
        repeat (10) @(posedge clk);
        #1;
        check_array("pe_tile1", g1);
      end
    join
    fork
      stream_wait(1'b0);
      begin
        repeat (10) @(posedge clk);
        #1;
        check_array("pe_tile1_plus_2", gsum);
      end
    join

    repeat (3) @(posedge clk);
    #1;
    chk("exp_queue_empty", exp_q.size(), 0);
    chk("done_pending", done_pend, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
